player_motion: RTL and testbench

- Per-player movement and animation engine, directly upstream of the sprite compositor / address-generation stage.
- Consumes the raw active-low controller button vector and the VGA frame tick.
- Produces the sprite's top-left screen position, facing direction and sprite-sheet frame offsets (anim_row/anim_col) that the compositor uses to index the character ROM.
- Adds walking, jumping, gravity, floor/platform landing and a walk-cycle animator; one instance per player.

---
 rtl/player_motion_if.sv | 21 ++
 rtl/player_motion.sv | 217 +++++++++++++++++++++
 tb/tb_player_motion.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_motion_if.sv
// Controller/frame-tick inputs and sprite placement outputs of one player.
interface player_motion_if;
    logic       frame_tick;
    logic [7:0] buttons;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       facing_right;
    logic [9:0] anim_row;
    logic [9:0] anim_col;
    logic       grounded;

    modport master (
        output frame_tick, buttons,
        input  pos_x, pos_y, facing_right, anim_row, anim_col, grounded
    );

    modport slave (
        input  frame_tick, buttons,
        output pos_x, pos_y, facing_right, anim_row, anim_col, grounded
    );
endinterface

// File: rtl/player_motion.sv
// Per-player movement and walk-cycle animation engine, updated once per frame.
module player_motion #(
    parameter int unsigned X_INIT     = 0,
    parameter int unsigned Y_INIT     = 0,
    parameter int unsigned X_MAX      = 610,
    parameter int unsigned FRAME_W    = 23,
    parameter int unsigned FRAME_H    = 30,
    parameter int unsigned FLOOR_Y    = 460,
    parameter int unsigned PLAT_X0    = 220,
    parameter int unsigned PLAT_X1    = 420,
    parameter int unsigned PLAT_Y     = 360,
    parameter int unsigned WALK_SPEED = 5,
    parameter int unsigned JUMP_VEL   = 15,
    parameter int unsigned GRAVITY    = 1,
    parameter int unsigned VMAX       = 10,
    parameter int unsigned ANIM_DIV   = 4
) (
    input logic             clk,
    input logic             rst,
    player_motion_if.slave  bus
);

    localparam int unsigned H2    = 2 * FRAME_H;
    localparam int unsigned W2    = 2 * FRAME_W;
    localparam int unsigned DIV_W = 8;

    localparam logic signed [10:0] H2_S    = 11'(H2);
    localparam logic signed [10:0] PLAT_S  = 11'(PLAT_Y);
    localparam logic signed [10:0] FLOOR_S = 11'(FLOOR_Y);
    localparam logic signed [10:0] VMAX_S  = 11'(VMAX);
    localparam logic        [7:0]  VY_JUMP = 8'(0) - 8'(JUMP_VEL);

    typedef enum logic {GROUND = 1'b0, AIR = 1'b1} state_t;

    state_t             state;
    logic               tick_q;
    logic [9:0]         x;
    logic [9:0]         y;
    logic signed [7:0]  vy;
    logic               facing;
    logic [2:0]         idx;
    logic [DIV_W-1:0]   div;
    logic               jump_prev;
    logic               drop;
    logic [9:0]         anim_row_q;
    logic [9:0]         anim_col_q;
    logic               grounded_q;

    logic               upd;
    logic               right;
    logic               left;
    logic               down;
    logic               right_only;
    logic               left_only;
    logic               moving;
    logic               jump_edge;
    logic               unused_buttons;

    logic signed [10:0] y_s;
    logic signed [10:0] vy_s;
    logic signed [10:0] ny;
    logic signed [10:0] vy_inc;
    logic        [7:0]  vy_fall;
    logic               falling;
    logic               overlap;
    logic               on_plat;
    logic               land_plat;
    logic               land_floor;
    logic               leave_ground;
    logic               air_next;

    logic [10:0]        x_sum;
    logic [9:0]         x_n;
    logic [2:0]         idx_n;
    logic [DIV_W-1:0]   div_n;
    logic [9:0]         row_n;
    logic [9:0]         col_n;

    // Button decode (active-low) and frame-tick rising-edge detect.
    assign upd            = bus.frame_tick & ~tick_q;
    assign right          = ~bus.buttons[0];
    assign left           = ~bus.buttons[1];
    assign down           = ~bus.buttons[2];
    assign right_only     = right & ~left;
    assign left_only      = left & ~right;
    assign moving         = right ^ left;
    assign jump_edge      = ~bus.buttons[7] & jump_prev;
    assign unused_buttons = ^bus.buttons[6:3];

    // Vertical kinematics and collision tests against the current position.
    assign y_s          = {1'b0, y};
    assign vy_s         = {{3{vy[7]}}, vy};
    assign ny           = y_s + vy_s;
    assign vy_inc       = vy_s + 11'(GRAVITY);
    assign vy_fall      = (vy_inc > VMAX_S) ? 8'(VMAX) : vy_inc[7:0];
    assign falling      = ~vy[7];
    assign overlap      = ((11'(x) + 11'(W2)) > 11'(PLAT_X0)) && (11'(x) < 11'(PLAT_X1));
    assign on_plat      = (y == 10'(PLAT_Y - H2));
    assign land_plat    = falling && ((y_s + H2_S) <= PLAT_S) && ((ny + H2_S) >= PLAT_S)
                          && overlap && !drop;
    assign land_floor   = falling && ((ny + H2_S) >= FLOOR_S);
    assign leave_ground = jump_edge || (down && on_plat) || (on_plat && !overlap);
    assign air_next     = (state == AIR) ? !(land_plat || land_floor) : leave_ground;

    // Horizontal step with saturation at both screen edges.
    always_comb begin
        x_n   = x;
        x_sum = 11'(x) + 11'(WALK_SPEED);
        if (right_only) begin
            x_n = (x_sum > 11'(X_MAX)) ? 10'(X_MAX) : x_sum[9:0];
        end else if (left_only) begin
            x_n = (x < 10'(WALK_SPEED)) ? 10'd0 : x - 10'(WALK_SPEED);
        end
    end

    // Walk-cycle index for the state the sprite will be in after this frame.
    always_comb begin
        idx_n = idx;
        div_n = div;
        if (air_next) begin
            idx_n = 3'd3;
            div_n = '0;
        end else if (!moving) begin
            idx_n = 3'd0;
            div_n = '0;
        end else if (div == DIV_W'(ANIM_DIV - 1)) begin
            div_n = '0;
            idx_n = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            div_n = div + DIV_W'(1);
        end
    end

    // Sprite-sheet offsets for the next index.
    always_comb begin
        row_n = (idx_n >= 3'd3) ? 10'(FRAME_H) : 10'd0;
        case (idx_n)
            3'd1, 3'd4: col_n = 10'(FRAME_W);
            3'd2, 3'd5: col_n = 10'(2 * FRAME_W);
            default:    col_n = 10'd0;
        endcase
    end

    // Ground/air state machine and all motion registers, stepped once per frame.
    always_ff @(posedge clk) begin
        tick_q <= bus.frame_tick;
        if (rst) begin
            state      <= AIR;
            x          <= 10'(X_INIT);
            y          <= 10'(Y_INIT);
            vy         <= '0;
            facing     <= 1'b1;
            idx        <= '0;
            div        <= '0;
            jump_prev  <= 1'b1;
            drop       <= 1'b0;
            anim_row_q <= '0;
            anim_col_q <= '0;
            grounded_q <= 1'b0;
        end else if (upd) begin
            x          <= x_n;
            jump_prev  <= bus.buttons[7];
            idx        <= idx_n;
            div        <= div_n;
            anim_row_q <= row_n;
            anim_col_q <= col_n;
            grounded_q <= !air_next;
            if (right_only) begin
                facing <= 1'b1;
            end else if (left_only) begin
                facing <= 1'b0;
            end
            case (state)
                GROUND: begin
                    if (jump_edge) begin
                        vy    <= VY_JUMP;
                        state <= AIR;
                    end else if (down && on_plat) begin
                        drop  <= 1'b1;
                        vy    <= '0;
                        state <= AIR;
                    end else if (on_plat && !overlap) begin
                        vy    <= '0;
                        state <= AIR;
                    end
                end
                AIR: begin
                    if (ny[10]) begin
                        y  <= '0;
                        vy <= '0;
                    end else if (land_plat) begin
                        y     <= 10'(PLAT_Y - H2);
                        vy    <= '0;
                        state <= GROUND;
                    end else if (land_floor) begin
                        y     <= 10'(FLOOR_Y - H2);
                        vy    <= '0;
                        drop  <= 1'b0;
                        state <= GROUND;
                    end else begin
                        y  <= ny[9:0];
                        vy <= vy_fall;
                    end
                end
                default: state <= AIR;
            endcase
        end
    end

    assign bus.pos_x        = x;
    assign bus.pos_y        = y;
    assign bus.facing_right = facing;
    assign bus.anim_row     = anim_row_q;
    assign bus.anim_col     = anim_col_q;
    assign bus.grounded     = grounded_q;

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: directed tables plus randomized model comparison.
module tb_player_motion;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    player_motion_if bus();

    player_motion #(.X_INIT(100), .Y_INIT(0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] btn;
        int ex, ey, ef, eg, er, ec;   // -1 = don't care
    } vec_t;

    vec_t vt[64];
    int   nvec = 0;
    int   vi   = 0;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state (plain integers).
    int mx, my, mvy, mg, mf, midx, mdiv, mjp, mdrop;

    function automatic void model_reset();
        mx = 100; my = 0; mvy = 0; mg = 0; mf = 1;
        midx = 0; mdiv = 0; mjp = 1; mdrop = 0;
    endfunction

    // One frame of the game rules, evaluated from the position at the start of the frame.
    function automatic void model_step(input logic [7:0] b);
        bit right = !b[0];
        bit left  = !b[1];
        bit down  = !b[2];
        bit a     = !b[7];
        int ox = mx;
        int oy = my;
        int ny;
        bit over;
        bit on_plat;
        if (right && !left) begin
            mx = (mx + 5 > 610) ? 610 : mx + 5;
            mf = 1;
        end else if (left && !right) begin
            mx = (mx < 5) ? 0 : mx - 5;
            mf = 0;
        end
        over    = (ox + 46 > 220) && (ox < 420);
        on_plat = (oy == 300);
        if (mg != 0) begin
            if (a && mjp != 0) begin
                mvy = -15; mg = 0;
            end else if (down && on_plat) begin
                mdrop = 1; mvy = 0; mg = 0;
            end else if (on_plat && !over) begin
                mvy = 0; mg = 0;
            end
        end else begin
            ny = oy + mvy;
            if (ny < 0) begin
                my = 0; mvy = 0;
            end else if (mvy >= 0 && oy + 60 <= 360 && ny + 60 >= 360 && over && mdrop == 0) begin
                my = 300; mvy = 0; mg = 1;
            end else if (mvy >= 0 && ny + 60 >= 460) begin
                my = 400; mvy = 0; mdrop = 0; mg = 1;
            end else begin
                my = ny;
                mvy = (mvy + 1 > 10) ? 10 : mvy + 1;
            end
        end
        mjp = int'(b[7]);
        if (mg == 0) begin
            midx = 3; mdiv = 0;
        end else if (right != left) begin
            mdiv++;
            if (mdiv == 4) begin
                mdiv = 0;
                midx = (midx + 1) % 6;
            end
        end else begin
            midx = 0; mdiv = 0;
        end
    endfunction

    task automatic add_vec(input logic [7:0] b, input int ex, ey, ef, eg, er, ec);
        vt[nvec].btn = b;
        vt[nvec].ex = ex; vt[nvec].ey = ey; vt[nvec].ef = ef;
        vt[nvec].eg = eg; vt[nvec].er = er; vt[nvec].ec = ec;
        nvec++;
    endtask

    task automatic check_out(input string name, input int ex, ey, ef, eg, er, ec);
        int ax = int'(bus.pos_x);
        int ay = int'(bus.pos_y);
        int af = int'(bus.facing_right);
        int ag = int'(bus.grounded);
        int ar = int'(bus.anim_row);
        int ac = int'(bus.anim_col);
        bit ok;
        ok = (ex < 0 || ax == ex) && (ey < 0 || ay == ey) && (ef < 0 || af == ef) &&
             (eg < 0 || ag == eg) && (er < 0 || ar == er) && (ec < 0 || ac == ec);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got x=%0d y=%0d face=%0d gnd=%0d row=%0d col=%0d, want x=%0d y=%0d face=%0d gnd=%0d row=%0d col=%0d",
                     name, ax, ay, af, ag, ar, ac, ex, ey, ef, eg, er, ec);
        end
    endtask

    task automatic check_model(input string name);
        check_out(name, mx, my, mf, mg, (midx >= 3) ? 30 : 0, (midx % 3) * 23);
    endtask

    // One frame: pulse frame_tick for two clocks, then sample after it falls.
    task automatic do_tick(input logic [7:0] b);
        @(negedge clk);
        bus.buttons    = b;
        bus.frame_tick = 1'b1;
        repeat (2) @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
        model_step(b);
    endtask

    task automatic walk(input logic [7:0] b, input int n, input string name);
        for (int i = 0; i < n; i++) begin
            do_tick(b);
            check_model(name);
        end
    endtask

    task automatic run_vecs(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            do_tick(vt[vi].btn);
            check_out(name, vt[vi].ex, vt[vi].ey, vt[vi].ef, vt[vi].eg, vt[vi].er, vt[vi].ec);
            vi++;
        end
    endtask

    task automatic run_until_grounded(input logic [7:0] b, input string name, output int min_y);
        min_y = 1023;
        for (int i = 0; i < 80; i++) begin
            do_tick(b);
            check_model(name);
            if (int'(bus.pos_y) < min_y) min_y = int'(bus.pos_y);
            if (bus.grounded) break;
        end
        vectors++;
        if (!bus.grounded) begin
            miscompares++;
            $display("FAIL %s_timeout: got grounded=%0d, want 1 within 80 frames", name, bus.grounded);
        end
    endtask

    initial begin
        int miny;
        int er5[6] = '{0, 0, 0, 30, 30, 30};
        int ec5[6] = '{0, 23, 46, 0, 23, 46};
        int ys[11] = '{0, 1, 3, 6, 10, 15, 21, 28, 36, 45, 55};

        // Free fall from reset.
        for (int i = 0; i < 11; i++) add_vec(8'hFF, 100, ys[i], 1, 0, 30, 0);
        // Right-edge saturation, both pressed, idle (from x=600 on the floor).
        add_vec(8'hFE, 605, 400, 1, 1, -1, -1);
        add_vec(8'hFE, 610, 400, 1, 1, -1, -1);
        add_vec(8'hFE, 610, 400, 1, 1, -1, -1);
        add_vec(8'hFC, 610, 400, 1, 1, 0, 0);
        add_vec(8'hFF, 610, 400, 1, 1, 0, 0);
        // Left-edge saturation (from x=5).
        add_vec(8'hFD, 0, 400, 0, 1, -1, -1);
        add_vec(8'hFD, 0, 400, 0, 1, -1, -1);
        add_vec(8'hFC, 0, 400, 0, 1, 0, 0);
        // Jump from floor at x=300, rising trajectory.
        add_vec(8'h7F, 300, 400, 1, 0, 30, 0);
        add_vec(8'hFF, 300, 385, 1, 0, 30, 0);
        add_vec(8'hFF, 300, 371, 1, 0, 30, 0);
        add_vec(8'hFF, 300, 358, 1, 0, 30, 0);
        // A held after landing on the platform: no retrigger until released.
        add_vec(8'h7F, 300, 300, 1, 1, 0, 0);
        add_vec(8'h7F, 300, 300, 1, 1, 0, 0);
        add_vec(8'h7F, 300, 300, 1, 1, 0, 0);
        add_vec(8'hFF, 300, 300, 1, 1, 0, 0);
        add_vec(8'h7F, 300, 300, 1, 0, 30, 0);
        // Walk cycle: one step every 4 frames, full cycle in 24.
        for (int t = 1; t <= 24; t++) add_vec(8'hFE, -1, 400, 1, 1, er5[(t / 4) % 6], ec5[(t / 4) % 6]);
        add_vec(8'hFF, -1, 400, 1, 1, 0, 0);

        rst = 1'b1;
        bus.frame_tick = 1'b0;
        bus.buttons    = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_out("reset", 100, 0, 1, 0, 0, 0);

        run_vecs(11, "fall_seq");
        run_until_grounded(8'hFF, "fall_land", miny);
        check_out("floor_land", 100, 400, 1, 1, 0, 0);
        repeat (6) @(negedge clk);
        check_out("hold_between_ticks", 100, 400, 1, 1, 0, 0);

        walk(8'hFE, 100, "walk_right");
        run_vecs(5, "right_sat");
        walk(8'hFD, 121, "walk_left");
        run_vecs(3, "left_sat");

        walk(8'hFE, 60, "walk_to_300");
        walk(8'hFF, 1, "idle");
        run_vecs(4, "jump_rise");
        run_until_grounded(8'hFF, "jump_arc", miny);
        vectors++;
        if (miny != 280) begin
            miscompares++;
            $display("FAIL jump_apex: got min_y=%0d, want 280", miny);
        end
        check_out("plat_land", 300, 300, 1, 1, 0, 0);

        do_tick(8'h7F);
        check_model("held_jump");
        run_until_grounded(8'h7F, "held_arc", miny);
        check_out("held_land", 300, 300, 1, 1, 0, 0);
        run_vecs(5, "no_retrigger");
        run_until_grounded(8'hFF, "rejump", miny);
        check_out("rejump_land", 300, 300, 1, 1, 0, 0);

        do_tick(8'hFB);
        check_out("drop", 300, 300, 1, 0, 30, 0);
        run_until_grounded(8'hFF, "drop_fall", miny);
        check_out("drop_land", 300, 400, 1, 1, 0, 0);

        do_tick(8'h7F);
        check_model("jump_again");
        run_until_grounded(8'hFF, "climb", miny);
        check_out("climb_land", 300, 300, 1, 1, 0, 0);
        walk(8'hFE, 23, "plat_walk");
        check_out("edge_415", 415, 300, 1, 1, -1, -1);
        do_tick(8'hFE);
        check_out("edge_420", 420, 300, 1, 1, -1, -1);
        do_tick(8'hFE);
        check_out("walk_off", 425, 300, 1, 0, 30, 0);
        run_until_grounded(8'hFF, "walk_off_fall", miny);
        check_out("walk_off_land", 425, 400, 1, 1, 0, 0);

        walk(8'hFF, 1, "anim_idle");
        run_vecs(25, "anim");

        for (int i = 0; i < 400; i++) begin
            do_tick(8'($urandom));
            check_model("random");
        end

        run_until_grounded(8'hFF, "pre_rst", miny);
        do_tick(8'h7F);
        check_model("rst_jump");
        walk(8'hFF, 7, "rst_rise");
        @(negedge clk);
        rst = 1'b1;
        bus.frame_tick = 1'b1;
        bus.buttons    = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        model_reset();
        check_out("rst_midjump", 100, 0, 1, 0, 0, 0);
        bus.frame_tick = 1'b0;
        do_tick(8'hFF);
        check_out("post_rst_tick", 100, 0, 1, 0, 30, 0);
        do_tick(8'hFF);
        check_out("post_rst_fall", 100, 1, 1, 0, 30, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
